// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: reset vector, canonical NOP and the fetch entry layout.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo2.sv
// Generic 2-entry synchronous FIFO; flush empties it, pushes while full are ignored unless a pop frees space.
module sync_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC generation, credit-limited memory requests, in-order response buffering
// and redirect flush with drop counting of stale responses.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [2:0] CREDITS = 3'(MAX_OUT);

  logic [31:0]  fetch_pc;
  logic [31:0]  target;
  logic [1:0]   out_cnt;
  logic [1:0]   out_cnt_next;
  logic [1:0]   drop_cnt;
  logic [2:0]   in_use;
  logic         accept;
  logic         resp;
  logic         keep_resp;
  logic         pop_head;

  logic [31:0]  pcq_head;
  logic         pcq_full;
  logic         pcq_empty;
  logic [1:0]   pcq_count;

  fetch_entry_t ibuf_in;
  fetch_entry_t ibuf_head;
  logic         ibuf_full;
  logic         ibuf_empty;
  logic [1:0]   ibuf_count;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high; valid never
  // depends on ready. imem_req/imem_ready is the request channel, instr_valid/instr_ready the
  // decode channel, and imem_rvalid is an unconditional response strobe.
  assign target       = redirect_pc & 32'hFFFF_FFFC;
  assign in_use       = {1'b0, out_cnt} + {1'b0, ibuf_count};
  assign imem_req     = !rst && !redirect && (in_use < CREDITS);
  assign imem_addr    = fetch_pc;
  assign accept       = imem_req && imem_ready;
  assign resp         = imem_rvalid && (out_cnt != 2'd0);
  assign keep_resp    = resp && (drop_cnt == 2'd0) && !redirect;
  assign out_cnt_next = out_cnt + 2'(accept) - 2'(resp);
  assign pop_head     = instr_valid && instr_ready && !redirect;

  assign ibuf_in.pc    = pcq_head;
  assign ibuf_in.instr = imem_rdata;

  sync_fifo2 #(.WIDTH(32)) u_pc_q (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (resp),
    .flush (1'b0),
    .wdata (fetch_pc),
    .rdata (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  sync_fifo2 #(.WIDTH(64)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (keep_resp),
    .pop   (pop_head),
    .flush (redirect),
    .wdata (ibuf_in),
    .rdata (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  // An empty buffer presents the reset-time NOP so decode never sees stale data.
  assign instr_valid = !ibuf_empty;
  assign instr       = ibuf_empty ? NOP_INSTR : ibuf_head.instr;
  assign pc          = ibuf_empty ? {RESET_PC[31:2], 2'b00} : ibuf_head.pc;
  assign pc_plus4    = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      out_cnt  <= 2'd0;
      drop_cnt <= 2'd0;
    end else begin
      out_cnt <= out_cnt_next;
      if (redirect) begin
        fetch_pc <= target;
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      // Everything still outstanding once this cycle's response retires belongs to the old path.
      if (redirect) begin
        drop_cnt <= out_cnt_next;
      end else if (resp && (drop_cnt != 2'd0)) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  resp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && out_cnt == 2'd0));
  pcq_tracks_out_cnt: assert property (@(posedge clk) disable iff (rst)
    (pcq_count == out_cnt) && (pcq_empty == (out_cnt == 2'd0)));
  pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(accept && pcq_full));
  ibuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(keep_resp && ibuf_full && !pop_head));

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage with a latency-programmable in-order memory and a decode scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          W        = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  fetch_stage #(.RESET_PC(RESET_PC), .MAX_OUT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always #5 clk = ~clk;

  // scoreboard and memory model state
  logic [W-1:0] exp_q[$];
  logic [31:0]  mem_addr_q[$];
  int           mem_due_q[$];
  logic [31:0]  model_pc;
  int           last_due;
  int           cyc;
  int           n_vec = 0;
  int           n_err = 0;

  // stimulus knobs
  int          lat;
  int          ready_mode;
  logic        dec_ready;
  logic        redir;
  logic [31:0] redir_pc;

  // per-cycle observations
  logic        obs_req, obs_valid, obs_rvalid, obs_acc, obs_ready;
  logic [31:0] obs_addr, obs_pc;
  int          n_pops;
  logic [31:0] pop_pc, pop_p4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    model_pc = RESET_PC;
    last_due = -1;
    cyc      = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    redir = 1'b0; redir_pc = '0; dec_ready = 1'b1; ready_mode = 0; lat = 1;
    @(posedge clk); @(posedge clk); #1;
    clear_model();
    rst = 1'b0;
  endtask

  // One clock: drive inputs at posedge+1, observe at posedge+2, then advance.
  task automatic tick();
    logic [W-1:0] e;
    int due;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    imem_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 2) == 1) : 1'b0;
    instr_ready = dec_ready;
    redirect    = redir;
    redirect_pc = redir_pc;
    #1;
    obs_req = imem_req; obs_valid = instr_valid; obs_rvalid = imem_rvalid;
    obs_ready = imem_ready; obs_addr = imem_addr; obs_pc = pc;
    obs_acc = imem_req && imem_ready;
    if (obs_acc) begin
      n_vec++;
      if (imem_addr !== model_pc) begin
        n_err++;
        $display("FAIL req_addr: cycle %0d got %h expected %h", cyc, imem_addr, model_pc);
      end
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (instr_valid && instr_ready && !redirect) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_instr: cycle %0d got pc %h instr %h expected none", cyc, pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({pc, instr} !== e) begin
          n_err++;
          $display("FAIL decode_entry: cycle %0d got pc %h instr %h expected pc %h instr %h",
                   cyc, pc, instr, e[63:32], e[31:0]);
        end
        n_vec++;
        if (pc_plus4 !== e[63:32] + 32'd4) begin
          n_err++;
          $display("FAIL pc_plus4: cycle %0d got %h expected %h", cyc, pc_plus4, e[63:32] + 32'd4);
        end
      end
      n_pops++;
      pop_pc = pc;
      pop_p4 = pc_plus4;
    end
    if (redirect) begin
      exp_q.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RESET_PC); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    n_vec++; if (instr !== NOP) begin n_err++; $display("FAIL rst_instr: got %h expected %h", instr, NOP); end
    n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h expected %h", pc, RESET_PC); end
    n_vec++; if (pc_plus4 !== RESET_PC + 32'd4) begin n_err++; $display("FAIL rst_pc_plus4: got %h expected %h", pc_plus4, RESET_PC + 32'd4); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] acc_addr [3];
    int n_acc = 0;
    int first_valid = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_acc && n_acc < 3) begin acc_addr[n_acc] = obs_addr; n_acc++; end
      if (obs_valid && first_valid < 0) first_valid = i;
    end
    n_vec++;
    if (n_acc != 3) begin n_err++; $display("FAIL first_accepts: got %0d expected 3", n_acc); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (acc_addr[k] !== 32'(k * 4)) begin
          n_err++; $display("FAIL first_addr%0d: got %h expected %h", k, acc_addr[k], 32'(k * 4));
        end
      end
    end
    n_vec++;
    if (first_valid != 2) begin n_err++; $display("FAIL first_valid_cycle: got %0d expected 2", first_valid); end
  endtask

  task automatic test_decode_stall();
    int p0;
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 3) begin
        n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL stall_req: cycle %0d got %b expected 0", i, obs_req); end
        n_vec++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: cycle %0d got %b expected 1", i, obs_valid); end
        n_vec++; if (obs_pc !== 32'h0) begin n_err++; $display("FAIL stall_pc: cycle %0d got %h expected 00000000", i, obs_pc); end
      end
    end
    dec_ready = 1'b1;
    p0 = n_pops;
    tick();
    n_vec++;
    if (n_pops != p0 + 1 || pop_pc !== 32'h0) begin
      n_err++; $display("FAIL stall_release: got pops %0d pc %h expected pops %0d pc 00000000", n_pops - p0, pop_pc, 1);
    end
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (n_pops - p0 < 4) begin n_err++; $display("FAIL stall_progress: got %0d pops expected at least 4", n_pops - p0); end
  endtask

  task automatic test_redirect_inflight();
    int p0;
    int b;
    do_reset();
    lat = 3;
    tick(); tick();
    n_vec++;
    if (mem_addr_q.size() != 2) begin n_err++; $display("FAIL redir_setup: got %0d outstanding expected 2", mem_addr_q.size()); end
    redir = 1'b1; redir_pc = 32'h0000_0103;
    tick();
    redir = 1'b0;
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b expected 0", obs_req); end
    p0 = n_pops;
    tick();
    n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_next: got %b expected 0", obs_valid); end
    b = 0;
    while (!obs_acc && b < 20) begin tick(); b++; end
    n_vec++;
    if (!obs_acc || obs_addr !== 32'h0000_0100) begin
      n_err++; $display("FAIL redir_target_addr: got %h (accepted %b) expected 00000100", obs_addr, obs_acc);
    end
    b = 0;
    while (n_pops == p0 && b < 20) begin tick(); b++; end
    n_vec++;
    if (n_pops == p0 || pop_pc !== 32'h0000_0100) begin
      n_err++; $display("FAIL redir_first_pc: got %h (pops %0d) expected 00000100", pop_pc, n_pops - p0);
    end
  endtask

  task automatic test_simultaneous();
    int p0;
    int b = 0;
    do_reset();
    while (!(instr_valid && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) && b < 10) begin tick(); b++; end
    redir = 1'b1; redir_pc = 32'h0000_0200;
    p0 = n_pops;
    tick();
    redir = 1'b0;
    n_vec++;
    if (!(obs_rvalid && obs_valid)) begin
      n_err++; $display("FAIL simul_setup: got rvalid %b valid %b expected 1 1", obs_rvalid, obs_valid);
    end
    tick();
    n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL simul_valid_next: got %b expected 0", obs_valid); end
    b = 0;
    while (n_pops == p0 && b < 10) begin tick(); b++; end
    n_vec++;
    if (n_pops == p0 || pop_pc !== 32'h0000_0200) begin
      n_err++; $display("FAIL simul_first_pc: got %h (pops %0d) expected 00000200", pop_pc, n_pops - p0);
    end
  endtask

  task automatic test_mem_backpressure();
    logic [31:0] refused;
    logic        have_refused = 1'b0;
    int n_acc = 0;
    int p0;
    do_reset();
    ready_mode = 1;
    p0 = n_pops;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (obs_req && !obs_ready) begin refused = obs_addr; have_refused = 1'b1; end
      if (obs_acc) begin
        n_acc++;
        if (have_refused) begin
          n_vec++;
          if (obs_addr !== refused) begin n_err++; $display("FAIL bp_hold_addr: got %h expected %h", obs_addr, refused); end
          have_refused = 1'b0;
        end
      end
    end
    n_vec++;
    if (n_acc < 6 || n_acc > 12) begin n_err++; $display("FAIL bp_accepts: got %0d expected 6..12", n_acc); end
    n_vec++;
    if (n_pops - p0 < 5) begin n_err++; $display("FAIL bp_pops: got %0d expected at least 5", n_pops - p0); end
  endtask

  task automatic test_wrap_reset();
    int p0;
    int b = 0;
    do_reset();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFE;
    tick();
    redir = 1'b0;
    p0 = n_pops;
    while (n_pops == p0 && b < 10) begin tick(); b++; end
    n_vec++;
    if (n_pops == p0 || pop_pc !== 32'hFFFF_FFFC || pop_p4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_first: got pc %h pc_plus4 %h expected FFFFFFFC 00000000", pop_pc, pop_p4);
    end
    b = 0;
    while (n_pops < p0 + 2 && b < 10) begin tick(); b++; end
    n_vec++;
    if (n_pops < p0 + 2 || pop_pc !== 32'h0) begin
      n_err++; $display("FAIL wrap_second: got pc %h expected 00000000", pop_pc);
    end
    tick(); tick();
    rst = 1'b1; redirect = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b1; instr_ready = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_req_comb: got %b expected 0", imem_req); end
    @(posedge clk); #1;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", instr_valid); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL midrst_addr: got %h expected %h", imem_addr, RESET_PC); end
    n_vec++; if (instr !== NOP) begin n_err++; $display("FAIL midrst_instr: got %h expected %h", instr, NOP); end
    n_vec++; if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4) begin
      n_err++; $display("FAIL midrst_pc: got %h/%h expected %h/%h", pc, pc_plus4, RESET_PC, RESET_PC + 32'd4);
    end
    clear_model();
    rst = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_drain();
    int b = 0;
    ready_mode = 2;
    dec_ready  = 1'b1;
    while ((exp_q.size() > 0 || mem_addr_q.size() > 0) && b < 30) begin tick(); b++; end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL drain: got %0d entries left expected 0", exp_q.size()); end
    n_vec++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b expected 0", instr_valid); end
  endtask

  initial begin
    n_pops = 0;
    clear_model();
    test_reset();
    test_first_fetch();
    test_decode_stall();
    test_redirect_inflight();
    test_simultaneous();
    test_mem_backpressure();
    test_wrap_reset();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
